tri_bus_reader: RTL and testbench

TRI_BUS_READER -- requirements
Module: tri_bus_reader

---
 rtl/tri_bus_reader_if.sv | 26 ++
 rtl/tri_bus_reader.sv | 102 ++++++++++
 tb/tb_tri_bus_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tri_bus_reader_if.sv
// Bundle for the tri-state bus reader. It carries the host request, the bus
// driver handshake and the read results.
//   master : host / bus-driver side. Drives rd_start, bus_vld and bus_data.
//   slave  : reader side. Drives bus_req, rdata, rdy, timeout and busy.
interface tri_bus_reader_if #(
    parameter int WIDTH = 8
);
    logic             rd_start;
    logic             bus_req;
    logic             bus_vld;
    logic [WIDTH-1:0] bus_data;
    logic [WIDTH-1:0] rdata;
    logic             rdy;
    logic             timeout;
    logic             busy;

    modport master (
        output rd_start, bus_vld, bus_data,
        input  bus_req, rdata, rdy, timeout, busy
    );

    modport slave (
        input  rd_start, bus_vld, bus_data,
        output bus_req, rdata, rdy, timeout, busy
    );
endinterface

// File: rtl/tri_bus_reader.sv
// Reads one word from a shared tri-state bus. On a host request it asks the
// bus driver to enable its output, waits up to TIMEOUT cycles for the driver
// strobe, and captures the word. It then spends one turnaround cycle before
// it accepts the next request.
// Ports:
//   clk  : clock; all state changes happen on the rising edge.
//   rst  : asynchronous, active-high reset.
//   bus  : tri_bus_reader_if.slave, which carries:
//            rd_start (in)  - host read request.
//            bus_vld  (in)  - driver strobe.
//            bus_data (in)  - bus data.
//            bus_req  (out) - request to the bus driver.
//            rdata    (out) - last captured word.
//            rdy      (out) - one-cycle pulse when rdata has been updated.
//            timeout  (out) - one-cycle pulse when a read is aborted.
//            busy     (out) - high in every state except IDLE.
//
// state | meaning
// IDLE  | waiting for rd_start
// WAIT  | bus_req high, waiting for bus_vld or the wait limit
// TURN  | one-cycle bus turnaround, bus_req low
module tri_bus_reader #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 8
) (
    input logic             clk,
    input logic             rst,
    tri_bus_reader_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             bus_req_q;
    logic             rdy_q;
    logic             timeout_q;
    logic             busy_q;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bus_req_q <= 1'b0;
            rdy_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // Both pulses default low, so each one can only last one cycle.
            rdy_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.rd_start) begin
                        state_q   <= S_WAIT;
                        cnt_q     <= '0;
                        bus_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // The strobe is tested first, so a word that arrives in
                    // the last allowed cycle is still captured.
                    if (bus.bus_vld) begin
                        rdata_q   <= bus.bus_data;
                        rdy_q     <= 1'b1;
                        bus_req_q <= 1'b0;
                        state_q   <= S_TURN;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        bus_req_q <= 1'b0;
                        state_q   <= S_TURN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_TURN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_req = bus_req_q;
    assign bus.rdata   = rdata_q;
    assign bus.rdy     = rdy_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_tri_bus_reader.sv
// Testbench for tri_bus_reader (WIDTH=8, TIMEOUT=8). A transaction-level model
// tracks the remaining wait budget and a turnaround flag. A compare process
// checks the DUT against the model at every falling edge, and directed
// scenarios pin the model with literal expectations.
module tb_tri_bus_reader;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tri_bus_reader_if #(.WIDTH(WIDTH)) bus ();

    tri_bus_reader #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state.
    bit             m_reading;
    bit             m_turn;
    int             m_left;
    bit             m_req, m_rdy, m_to, m_busy;
    logic [WIDTH-1:0] m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reading = 0; m_turn = 0; m_left = 0;
            m_req = 0; m_rdy = 0; m_to = 0; m_busy = 0; m_rdata = '0;
        end else begin
            m_rdy = 0;
            m_to  = 0;
            if (m_turn) begin
                m_turn = 0;
                m_busy = 0;
            end else if (m_reading) begin
                if (bus.bus_vld) begin
                    m_rdata = bus.bus_data;
                    m_rdy = 1; m_reading = 0; m_turn = 1; m_req = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_to = 1; m_reading = 0; m_turn = 1; m_req = 0;
                    end
                end
            end else if (bus.rd_start) begin
                m_reading = 1; m_left = TIMEOUT; m_req = 1; m_busy = 1;
            end
        end
    end

    // Event counters, sampled at the falling edge.
    int  cyc = 0;
    int  rdy_cnt, to_cnt, req_cnt, last_rdy, min_gap;
    bit  prev_rdy, prev_to;

    task automatic clear_counts();
        rdy_cnt = 0; to_cnt = 0; req_cnt = 0; last_rdy = -1; min_gap = 1000;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.rdy === 1'b1) begin
            rdy_cnt++;
            if (last_rdy >= 0 && (cyc - last_rdy) < min_gap) min_gap = cyc - last_rdy;
            last_rdy = cyc;
        end
        if (bus.timeout === 1'b1) to_cnt++;
        if (bus.bus_req === 1'b1) req_cnt++;
    end

    // Compare the DUT against the model on every cycle.
    always @(negedge clk) begin
        chk("bus_req", {31'd0, bus.bus_req}, {31'd0, m_req});
        chk("rdy",     {31'd0, bus.rdy},     {31'd0, m_rdy});
        chk("timeout", {31'd0, bus.timeout}, {31'd0, m_to});
        chk("busy",    {31'd0, bus.busy},    {31'd0, m_busy});
        chk("rdata",   {24'd0, bus.rdata},   {24'd0, m_rdata});
        chk("rdy_to_excl", {31'd0, bus.rdy & bus.timeout}, 32'd0);
        chk("rdy_single",  {31'd0, bus.rdy & prev_rdy}, 32'd0);
        chk("to_single",   {31'd0, bus.timeout & prev_to}, 32'd0);
        prev_rdy = bus.rdy;
        prev_to  = bus.timeout;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    initial begin
        bus.rd_start = 1'b0;
        bus.bus_vld  = 1'b0;
        bus.bus_data = '0;
        prev_rdy = 1'b0;
        prev_to  = 1'b0;
        clear_counts();
        #1;
        chk("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
        chk("rst_rdy",     {31'd0, bus.rdy}, 32'd0);
        chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
        chk("rst_rdata",   {24'd0, bus.rdata}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Basic read of A5: strobe arrives two cycles after bus_req rises.
        clear_counts();
        bus.rd_start = 1'b1;
        tick();
        chk("a5_req_up", {31'd0, bus.bus_req}, 32'd1);
        chk("a5_busy_up", {31'd0, bus.busy}, 32'd1);
        bus.rd_start = 1'b0;
        tick();
        bus.bus_vld = 1'b1; bus.bus_data = 8'hA5;
        tick();
        bus.bus_vld = 1'b0;
        chk("a5_rdata", {24'd0, bus.rdata}, 32'h0000_00A5);
        chk("a5_rdy", {31'd0, bus.rdy}, 32'd1);
        chk("a5_req_low", {31'd0, bus.bus_req}, 32'd0);
        tick();
        chk("a5_rdy_gone", {31'd0, bus.rdy}, 32'd0);
        tick();
        chk("a5_busy_low", {31'd0, bus.busy}, 32'd0);

        // Timeout: bus_vld is held low for the whole read.
        clear_counts();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (12) tick();
        chk("to_req_cycles", req_cnt, 32'd8);
        chk("to_pulses", to_cnt, 32'd1);
        chk("to_no_rdy", rdy_cnt, 32'd0);
        chk("to_rdata_kept", {24'd0, bus.rdata}, 32'h0000_00A5);

        // Strobe in the 8th WAIT cycle beats the timeout.
        clear_counts();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (7) tick();
        bus.bus_vld = 1'b1; bus.bus_data = 8'h3C;
        tick();
        bus.bus_vld = 1'b0;
        chk("last_rdy", {31'd0, bus.rdy}, 32'd1);
        chk("last_rdata", {24'd0, bus.rdata}, 32'h0000_003C);
        chk("last_no_to", {31'd0, bus.timeout}, 32'd0);
        repeat (3) tick();
        chk("last_to_cnt", to_cnt, 32'd0);

        // Back-to-back reads: rd_start and bus_vld are held high.
        clear_counts();
        bus.rd_start = 1'b1;
        bus.bus_vld  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.bus_data = 8'(i * 17 + 1);
            tick();
        end
        bus.rd_start = 1'b0;
        bus.bus_vld  = 1'b0;
        chk("b2b_rdata", {24'd0, bus.rdata}, 32'd171);
        repeat (3) tick();
        chk("b2b_rdy_cnt", rdy_cnt, 32'd4);
        chk("b2b_gap", min_gap, 32'd3);

        // Asynchronous reset between edges in the 4th WAIT cycle.
        clear_counts();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (3) tick();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_rdata", {24'd0, bus.rdata}, 32'd0);
        tick();
        rst = 1'b0;
        bus.rd_start = 1'b1;
        tick();
        chk("arst_reaccept", {31'd0, bus.bus_req}, 32'd1);
        bus.rd_start = 1'b0;
        bus.bus_vld = 1'b1; bus.bus_data = 8'h5A;
        tick();
        bus.bus_vld = 1'b0;
        chk("arst_read_rdy", {31'd0, bus.rdy}, 32'd1);
        chk("arst_read_data", {24'd0, bus.rdata}, 32'h0000_005A);
        chk("arst_no_to", to_cnt, 32'd0);
        chk("arst_one_rdy", rdy_cnt, 32'd1);
        tick(); tick();

        // bus_vld/bus_data must be ignored in IDLE and TURN.
        clear_counts();
        bus.bus_vld = 1'b1; bus.bus_data = 8'hFF;
        tick(); tick();
        chk("idle_ignore_data", {24'd0, bus.rdata}, 32'h0000_005A);
        chk("idle_ignore_rdy", rdy_cnt, 32'd0);
        bus.bus_vld = 1'b0;
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        bus.bus_vld = 1'b1; bus.bus_data = 8'h11;
        tick();
        bus.bus_data = 8'hFF;
        tick(); tick();
        bus.bus_vld = 1'b0;
        chk("turn_ignore_data", {24'd0, bus.rdata}, 32'h0000_0011);
        chk("turn_one_rdy", rdy_cnt, 32'd1);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
